iob_diff: RTL and testbench
===========================

Name: iob_diff

Overview:
- Streaming first-difference (differentiator) block; the inverse of the team's accumulator.
- Accepts samples on a valid/ready input and emits out = x[n] - x[n-1] on a valid/ready output, with a 1-entry output register.
- Chaining iob_diff into the accumulator, with rst_val equal to ref_val, reconstructs the original sample stream.
- Used for delta-compressing counters and timestamps before transmission or storage.

Parameters:
- DATA_W, 32, sample and delta width in bits; two's-complement.
- CNT_W, 16, width of the emitted-delta counter.
- DROP_FIRST, 0, if 1 the first sample after reset/clr only seeds the history and produces no output.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- clr  input  1  synchronous clear: reload history from ref_val, flush output, zero counter
- ref_val  input  DATA_W  history value loaded on rst/clr; the first delta is x[0]-ref_val
- in_valid  input  1  input sample valid
- in_ready  output  1  block can accept a sample this cycle
- in_data  input  DATA_W  input sample
- out_valid  output  1  out_data holds a delta
- out_ready  input  1  downstream accepts the delta
- out_data  output  DATA_W  delta
- out_ovf  output  1  delta overflowed signed range; qualified by out_valid
- out_cnt  output  CNT_W  number of deltas handed off (out_valid & out_ready), wraps

Behaviour:
- Reset (async rst high):
  - prev <= ref_val, out_valid=0, out_data=0, out_ovf=0, out_cnt=0, state=FIRST.
  - ref_val is sampled at the clk edge after rst deasserts, not during the asynchronous assertion. prev therefore loads ref_val on the first clk edge with rst low, and no input is accepted on that edge (in_ready=0 for the first cycle after reset).
- in_ready = !clr & !init & (!out_valid | out_ready), where init is high for exactly one cycle after rst release.
- Accept = in_valid & in_ready. On accept:
  - prev <= in_data.
  - If state=FIRST and DROP_FIRST=1: no output is produced; state <= RUN.
  - Otherwise: out_data <= in_data - prev (DATA_W-bit subtraction), out_ovf per the Optional Feature, out_valid <= 1, state <= RUN.
- Latency: delta is valid the cycle after accept. Throughput: 1 sample/cycle while out_ready is held high.
- Output hold: while out_valid & !out_ready, out_data and out_ovf are stable and in_ready=0.
- Handoff: out_valid & out_ready & !accept -> out_valid <= 0. Handoff and accept in the same cycle -> out_valid stays 1 with the new delta.
- out_cnt increments on every handoff and wraps 2^CNT_W-1 -> 0.
- State machine: FIRST -> RUN on the first accept; RUN -> FIRST on clr. State only changes behaviour when DROP_FIRST=1.
- clr (sync, highest priority after rst):
  - prev <= ref_val, out_valid <= 0 (a pending delta is discarded and not counted), out_cnt <= 0, state <= FIRST.
  - in_ready=0 during the clr cycle.
- Arithmetic:
  - Without saturation, wrap-around is exact modulo 2^DATA_W. This is what makes accumulator reconstruction bit-exact.
  - out_ovf = signed overflow of (in_data - prev): the operands' signs differ and the result sign differs from in_data's sign.
- rst mid-transfer: the pending delta is lost and history returns to ref_val.

Optional Feature:
- Macro: IOB_DIFF_SAT_EN.
- Defined: on signed overflow, out_data saturates to 2^(DATA_W-1)-1 (positive overflow) or -2^(DATA_W-1) (negative overflow), and out_ovf=1. prev always stores the raw in_data.
- Undefined: out_data is the wrapped difference. out_ovf still reports overflow as an informational flag.

Decomposition:
- Shared package (iob_diff_pkg):
  - state encoding constants: FIRST=1'b0, RUN=1'b1.
  - signed-limit constants, MAX_POS/MAX_NEG as functions of DATA_W.
- One natural sub-module, iob_diff_sub: combinational subtract, overflow detect and optional saturation; it is the only place IOB_DIFF_SAT_EN is tested.
- The top level holds the history register, output register, state, counter and handshake.

Test Plan:
- Basic stream: rst, ref_val=0, DATA_W=32, feed 5,8,8,3 with out_ready=1 -> deltas 5,3,0,-5 (0xFFFFFFFB), each 1 cycle after accept; out_cnt=4.
- Backpressure: out_ready=0 for 3 cycles after the first delta -> in_ready=0, out_data held; release -> remaining deltas in order, none lost or duplicated.
- Wrap/overflow: prev=0x7FFFFFFF, next sample 0x80000000 -> out_ovf=1; out_data=0x00000001 without the macro; with the macro, the sample 0x80000000 after prev=0x7FFFFFFF yields 0x80000000 (negative saturation) and the reverse order yields 0x7FFFFFFF.
- DROP_FIRST=1, ref_val=100: feed 110,115 -> single delta 5; out_cnt=1.
- clr with a pending delta (out_ready=0), ref_val=50: delta discarded, out_cnt=0; next sample 60 -> delta 10.
- Round trip: iob_diff output into the accumulator (rst_val=ref_val=0x1234, en=handoff) over 1000 random samples -> accumulator output equals each input sample, macro undefined.

Source files
------------

// File: rtl/iob_diff_pkg.sv
// Shared definitions for the iob_diff streaming differentiator.
// Optional saturation is selected with the IOB_DIFF_SAT_EN macro (see iob_diff_sub).
package iob_diff_pkg;

  typedef enum logic {
    FIRST = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Signed limits as raw bit patterns; callers keep the low w bits (w <= 64).
  function automatic logic [63:0] max_pos(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] max_neg(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/iob_diff_sub.sv
// Combinational subtract (a - b) with signed-overflow detect.
// Saturation on overflow is enabled by defining IOB_DIFF_SAT_EN.
module iob_diff_sub
  import iob_diff_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] diff,
  output logic              ovf
);

  localparam logic [63:0] MAX_POS_W = max_pos(DATA_W);
  localparam logic [63:0] MAX_NEG_W = max_neg(DATA_W);
  localparam logic signed [DATA_W-1:0] MAX_POS = MAX_POS_W[DATA_W-1:0];
  localparam logic signed [DATA_W-1:0] MAX_NEG = MAX_NEG_W[DATA_W-1:0];

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic signed [DATA_W-1:0] raw;

  // The direction of overflow follows the minuend's sign: a negative a can only underflow.
  function automatic logic signed [DATA_W-1:0] saturate(
    input logic signed [DATA_W-1:0] val,
    input logic                     over,
    input logic                     neg
  );
    if (!over) return val;
    return neg ? MAX_NEG : MAX_POS;
  endfunction

  assign a_s = $signed(a);
  assign b_s = $signed(b);
  assign raw = a_s - b_s;
  assign ovf = (a_s[DATA_W-1] ^ b_s[DATA_W-1]) & (raw[DATA_W-1] ^ a_s[DATA_W-1]);

`ifdef IOB_DIFF_SAT_EN
  assign diff = saturate(raw, ovf, a_s[DATA_W-1]);
`else
  assign diff = raw;
`endif

endmodule

// File: rtl/iob_diff.sv
// Streaming first-difference: out = x[n] - x[n-1] behind a 1-entry output register.
// Build-time option: IOB_DIFF_SAT_EN saturates overflowing deltas instead of wrapping.
module iob_diff
  import iob_diff_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16,
  parameter int DROP_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [DATA_W-1:0] ref_val,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ovf,
  output logic [CNT_W-1:0]  out_cnt
);

  state_t            state;
  logic              init;
  logic [DATA_W-1:0] prev_p0;
  logic [DATA_W-1:0] diff_p0;
  logic              ovf_p0;
  logic              accept;
  logic              handoff;
  logic              drop;

  assign in_ready = !clr && !init && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid && out_ready;
  assign drop     = (DROP_FIRST != 0) && (state == FIRST);

  iob_diff_sub #(
    .DATA_W(DATA_W)
  ) u_sub (
    .a   (in_data),
    .b   (prev_p0),
    .diff(diff_p0),
    .ovf (ovf_p0)
  );

  // Stage p0 -> p1: history, output register, counter and state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init      <= 1'b1;
      prev_p0   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_cnt   <= '0;
      state     <= FIRST;
    end else if (clr) begin
      init      <= 1'b0;
      prev_p0   <= ref_val;
      out_valid <= 1'b0;
      out_cnt   <= '0;
      state     <= FIRST;
    end else if (init) begin
      // ref_val is only loaded synchronously, one edge after rst release.
      init    <= 1'b0;
      prev_p0 <= ref_val;
    end else begin
      if (handoff) out_cnt <= out_cnt + CNT_W'(1);
      if (accept) begin
        prev_p0 <= in_data;
        state   <= RUN;
        if (drop) begin
          if (handoff) out_valid <= 1'b0;
        end else begin
          out_data  <= diff_p0;
          out_ovf   <= ovf_p0;
          out_valid <= 1'b1;
        end
      end else if (handoff) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iob_diff.sv
// Randomized self-checking bench for iob_diff with a queue-based reference model
// and an accumulator round-trip check; a second instance covers DROP_FIRST=1.
module tb_iob_diff;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clr = 1'b0;
  logic [DATA_W-1:0] ref_val = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_ovf;
  logic [CNT_W-1:0]  out_cnt;

  logic              d2_clr = 1'b0;
  logic [DATA_W-1:0] d2_ref_val = 32'd100;
  logic              d2_in_valid = 1'b0;
  logic              d2_in_ready;
  logic [DATA_W-1:0] d2_in_data = '0;
  logic              d2_out_valid;
  logic              d2_out_ready = 1'b1;
  logic [DATA_W-1:0] d2_out_data;
  logic              d2_out_ovf;
  logic [CNT_W-1:0]  d2_out_cnt;

  always #5 clk = ~clk;

  iob_diff #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DROP_FIRST(0)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .ref_val(ref_val),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .out_cnt(out_cnt)
  );

  iob_diff #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DROP_FIRST(1)) u_dut_drop (
    .clk(clk), .rst(rst), .clr(d2_clr), .ref_val(d2_ref_val),
    .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_data(d2_in_data),
    .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_data(d2_out_data),
    .out_ovf(d2_out_ovf), .out_cnt(d2_out_cnt)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              ovf;
  } exp_t;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] sent_q[$];
  logic [DATA_W-1:0] m_prev;
  logic [CNT_W-1:0]  m_cnt;
  logic [DATA_W-1:0] acc;
  bit                rt_en = 1'b0;
  int                rt_total = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference delta from full-precision integer arithmetic.
  function automatic exp_t model_delta(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] p);
    exp_t   e;
    longint w;
    w     = longint'($signed(x)) - longint'($signed(p));
    e.ovf = (w > 64'sd2147483647) || (w < -64'sd2147483648);
    e.data = x - p;
`ifdef IOB_DIFF_SAT_EN
    if (e.ovf) e.data = (w > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    return e;
  endfunction

  task automatic do_reset(input logic [DATA_W-1:0] rv);
    @(negedge clk);
    rst = 1'b1; ref_val = rv; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_out_cnt", out_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("init_in_ready", in_ready, 0);
    exp_q.delete(); sent_q.delete();
    m_prev = rv; m_cnt = '0; acc = rv;
  endtask

  // One clock cycle: drive, check against the model, then advance the model.
  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic ordy, input logic c);
    logic exp_rdy;
    exp_t e;
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = ordy; clr = c;
    #1;
    exp_rdy = !c && (exp_q.size() == 0 || ordy);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("out_data", out_data, exp_q[0].data);
      chk("out_ovf", out_ovf, exp_q[0].ovf);
    end
    chk("out_cnt", out_cnt, m_cnt);
    if (c) begin
      exp_q.delete(); sent_q.delete();
      m_prev = ref_val; m_cnt = '0;
    end else begin
      if (exp_q.size() != 0 && ordy) begin
        void'(exp_q.pop_front());
        m_cnt++;
`ifndef IOB_DIFF_SAT_EN
        if (rt_en) begin
          acc = acc + out_data;
          chk("recon", acc, sent_q.pop_front());
        end
`endif
      end
      if (v && exp_rdy) begin
        e = model_delta(d, m_prev);
        exp_q.push_back(e);
        sent_q.push_back(d);
        m_prev = d;
        rt_total++;
      end
    end
  endtask

  initial begin
    logic [DATA_W-1:0] x;

    // Basic stream
    do_reset(32'd0);
    step(1, 32'd5, 1, 0); step(1, 32'd8, 1, 0); step(1, 32'd8, 1, 0); step(1, 32'd3, 1, 0);
    step(0, 32'd0, 1, 0); step(0, 32'd0, 1, 0);
    chk("basic_cnt", out_cnt, 4);

    // Backpressure
    step(1, 32'd10, 1, 0);
    repeat (3) step(1, 32'd20, 0, 0);
    step(1, 32'd20, 1, 0); step(1, 32'd35, 1, 0);
    step(0, 32'd0, 1, 0); step(0, 32'd0, 1, 0);

    // Overflow both directions
    step(1, 32'h7FFF_FFFF, 1, 0); step(1, 32'h8000_0000, 1, 0); step(1, 32'h7FFF_FFFF, 1, 0);
    step(0, 32'd0, 0, 0);
    chk("ovf_flag_pos", out_ovf, 1);
`ifdef IOB_DIFF_SAT_EN
    chk("ovf_sat_pos", out_data, 32'h7FFF_FFFF);
`else
    chk("ovf_wrap_pos", out_data, 32'hFFFF_FFFF);
`endif
    step(0, 32'd0, 1, 0);

    // clr with a pending delta
    ref_val = 32'd50;
    step(1, 32'd77, 0, 0);
    step(0, 32'd0, 0, 1);
    step(1, 32'd60, 1, 0);
    step(0, 32'd0, 1, 0);
    chk("clr_delta", out_data, 10);
    chk("clr_cnt", out_cnt, 0);
    step(0, 32'd0, 1, 0);

    // DROP_FIRST instance
    do_reset(32'd0);
    @(negedge clk);
    d2_in_valid = 1'b1; d2_in_data = 32'd110;
    #1;
    chk("drop_rdy0", d2_in_ready, 1);
    chk("drop_vld0", d2_out_valid, 0);
    @(negedge clk);
    d2_in_data = 32'd115;
    #1;
    chk("drop_vld1", d2_out_valid, 0);
    @(negedge clk);
    d2_in_valid = 1'b0;
    #1;
    chk("drop_vld2", d2_out_valid, 1);
    chk("drop_data", d2_out_data, 5);
    @(negedge clk);
    #1;
    chk("drop_vld3", d2_out_valid, 0);
    chk("drop_cnt", d2_out_cnt, 1);

    // Random stream with accumulator round trip
    do_reset(32'h1234);
    rt_en = 1'b1; rt_total = 0; x = 32'h1234;
    for (int cyc = 0; cyc < 6000 && rt_total < 1000; cyc++) begin
      if ($urandom_range(0, 1) == 0) x = $urandom;
      else x = x + DATA_W'($urandom_range(0, 64)) - 32'd32;
      step($urandom_range(0, 3) != 0, x, $urandom_range(0, 3) != 0, 0);
    end
    repeat (3) step(0, 32'd0, 1, 0);
    chk("rt_samples", rt_total, 1000);
    chk("rt_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
